// File: rtl/cache_pkg.sv
// Shared definitions for the two-way data cache: controller states,
// RISC-V load/store size codes and address-field width helpers.
package cache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_REFILL    = 2'd2
   } cache_state_e;

   // funct3 size/sign codes for loads and stores
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Byte-offset-within-line width: word offset bits plus the two byte bits
   function automatic int off_bits(input int words_per_line);
      return $clog2(words_per_line) + 2;
   endfunction

   function automatic int idx_bits(input int num_sets);
      return $clog2(num_sets);
   endfunction

   function automatic int tag_bits(input int addr_width, input int words_per_line,
                                   input int num_sets);
      return addr_width - off_bits(words_per_line) - idx_bits(num_sets);
   endfunction

endpackage

// File: rtl/cache_lane_align.sv
// Byte-lane handling for one cached word: load extraction with sign/zero
// extension, and merging of byte/half/word store data into the old word.
module cache_lane_align #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2:0]            funct3,
   input  logic [1:0]            byte_off,
   input  logic [DATA_WIDTH-1:0] word_in,
   input  logic [DATA_WIDTH-1:0] store_in,
   output logic [DATA_WIDTH-1:0] load_out,
   output logic [DATA_WIDTH-1:0] store_out
);
   import cache_pkg::*;

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed lane and extend it; halves use addr[1] only
   always_comb begin
      byte_sel = word_in[{byte_off, 3'b000} +: 8];
      half_sel = word_in[{byte_off[1], 4'b0000} +: 16];
      case (funct3)
         F3_B:    load_out = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
         F3_H:    load_out = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
         F3_BU:   load_out = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
         F3_HU:   load_out = {{(DATA_WIDTH-16){1'b0}}, half_sel};
         default: load_out = word_in;
      endcase
   end

   // Overwrite only the addressed lane; other lanes keep the stored value
   always_comb begin
      store_out = word_in;
      case (funct3)
         F3_B:    store_out[{byte_off, 3'b000} +: 8]      = store_in[7:0];
         F3_H:    store_out[{byte_off[1], 4'b0000} +: 16] = store_in[15:0];
         default: store_out = store_in;
      endcase
   end

endmodule

// File: rtl/dcache_2way.sv
// Two-way set-associative write-back/write-allocate data cache with one
// LRU bit per set. Hits complete combinationally; misses optionally write
// back the dirty victim, refill the line, then re-look-up in IDLE.
// Handshake: mem_req is held with stable mem_we/mem_addr/mem_wdata until a
// one-cycle mem_ready pulse completes the transfer at that rising edge; the
// CPU holds req_* stable while stall=1.
module dcache_2way
   import cache_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int WORDS_PER_LINE = 4,
   parameter int NUM_SETS       = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 req_valid,
   input  logic                                 req_we,
   input  logic [ADDR_WIDTH-1:0]                req_addr,
   input  logic [DATA_WIDTH-1:0]                req_wdata,
   input  logic [2:0]                           req_funct3,
   output logic [DATA_WIDTH-1:0]                rdata,
   output logic                                 stall,
   output logic                                 hit,
   output logic                                 mem_req,
   output logic                                 mem_we,
   output logic [ADDR_WIDTH-1:0]                mem_addr,
   output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] mem_wdata,
   input  logic [WORDS_PER_LINE*DATA_WIDTH-1:0] mem_rdata,
   input  logic                                 mem_ready
);

   localparam int OFF_W  = off_bits(WORDS_PER_LINE);
   localparam int WOFF_W = $clog2(WORDS_PER_LINE);
   localparam int IDX_W  = idx_bits(NUM_SETS);
   localparam int TAG_W  = tag_bits(ADDR_WIDTH, WORDS_PER_LINE, NUM_SETS);
   localparam int LINE_W = WORDS_PER_LINE * DATA_WIDTH;

   logic [DATA_WIDTH-1:0] data_q  [2][NUM_SETS][WORDS_PER_LINE];
   logic [TAG_W-1:0]      tag_q   [2][NUM_SETS];
   logic [NUM_SETS-1:0]   valid_q [2];
   logic [NUM_SETS-1:0]   dirty_q [2];
   logic [NUM_SETS-1:0]   lru_q;      // way to evict next in each set
   cache_state_e          state_q, state_d;
   logic                  victim_q;   // victim way latched on the miss cycle

   logic [TAG_W-1:0]      req_tag;
   logic [IDX_W-1:0]      req_idx;
   logic [WOFF_W-1:0]     req_woff;
   logic                  hit_w0, hit_w1, lookup_hit, hit_way, victim_c;
   logic [DATA_WIDTH-1:0] hit_word, load_word, merged_word;
   logic [LINE_W-1:0]     victim_line;
   logic                  hit_en, store_en, miss_en, refill_en;

   assign req_tag  = req_addr[ADDR_WIDTH-1 -: TAG_W];
   assign req_idx  = req_addr[OFF_W +: IDX_W];
   assign req_woff = req_addr[2 +: WOFF_W];

   // Tag compare in both ways and victim choice (invalid way first, else LRU)
   always_comb begin
      hit_w0     = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
      hit_w1     = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
      lookup_hit = hit_w0 || hit_w1;
      hit_way    = !hit_w0 && hit_w1;
      hit_word   = data_q[hit_way][req_idx][req_woff];
      if (!valid_q[0][req_idx])      victim_c = 1'b0;
      else if (!valid_q[1][req_idx]) victim_c = 1'b1;
      else                           victim_c = lru_q[req_idx];
   end

   // Pack the latched victim line, word 0 in the LSBs
   always_comb begin
      victim_line = '0;
      for (int w = 0; w < WORDS_PER_LINE; w++)
         victim_line[w*DATA_WIDTH +: DATA_WIDTH] = data_q[victim_q][req_idx][w];
   end

   cache_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .funct3    (req_funct3),
      .byte_off  (req_addr[1:0]),
      .word_in   (hit_word),
      .store_in  (req_wdata),
      .load_out  (load_word),
      .store_out (merged_word)
   );

   // Next state, outputs and update enables; everything is quiet in reset
   always_comb begin
      state_d   = state_q;
      stall     = 1'b0;
      hit       = 1'b0;
      rdata     = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      hit_en    = 1'b0;
      store_en  = 1'b0;
      miss_en   = 1'b0;
      refill_en = 1'b0;
      if (rst_n) begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  if (lookup_hit) begin
                     hit      = 1'b1;
                     rdata    = load_word;
                     hit_en   = 1'b1;
                     store_en = req_we;
                  end else begin
                     stall   = 1'b1;
                     miss_en = 1'b1;
                     if (valid_q[victim_c][req_idx] && dirty_q[victim_c][req_idx])
                        state_d = ST_WRITEBACK;
                     else
                        state_d = ST_REFILL;
                  end
               end
            end
            ST_WRITEBACK: begin
               stall     = 1'b1;
               mem_req   = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = {tag_q[victim_q][req_idx], req_idx, {OFF_W{1'b0}}};
               mem_wdata = victim_line;
               if (mem_ready) state_d = ST_REFILL;
            end
            ST_REFILL: begin
               stall    = 1'b1;
               mem_req  = 1'b1;
               mem_addr = {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
               if (mem_ready) begin
                  refill_en = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State, valid/dirty/LRU bookkeeping; reset discards all lines
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         valid_q[0] <= '0;
         valid_q[1] <= '0;
         dirty_q[0] <= '0;
         dirty_q[1] <= '0;
         lru_q      <= '0;
         victim_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (miss_en)  victim_q <= victim_c;
         if (hit_en)   lru_q[req_idx] <= ~hit_way;
         if (store_en) dirty_q[hit_way][req_idx] <= 1'b1;
         if (refill_en) begin
            valid_q[victim_q][req_idx] <= 1'b1;
            dirty_q[victim_q][req_idx] <= 1'b0;
         end
      end
   end

   // Data and tag arrays: store-hit merge and line refill (not reset)
   always_ff @(posedge clk) begin
      if (store_en)
         data_q[hit_way][req_idx][req_woff] <= merged_word;
      if (refill_en) begin
         for (int w = 0; w < WORDS_PER_LINE; w++)
            data_q[victim_q][req_idx][w] <= mem_rdata[w*DATA_WIDTH +: DATA_WIDTH];
         tag_q[victim_q][req_idx] <= req_tag;
      end
   end

endmodule

// File: tb/tb_dcache_2way.sv
// Directed bench for dcache_2way: hand-computed vectors covering reset,
// refill, load extension, store merging, eviction, write-back, a long
// memory stall and reset in the middle of a refill.
module tb_dcache_2way;

   localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010;
   localparam logic [2:0] LBU = 3'b100, LHU = 3'b101, SB = 3'b000, SH = 3'b001, SW = 3'b010;

   localparam logic [127:0] LINE_A = {32'd4, 32'd3, 32'd2, 32'd1};
   localparam logic [127:0] LINE_B = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
   localparam logic [127:0] LINE_C = {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000};
   localparam logic [127:0] LINE_D = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
   localparam logic [127:0] WB_C   = {32'hC000_0003, 32'hC000_0002, 32'h1234_5678, 32'hC000_0000};
   localparam logic [127:0] WB_A   = {32'd4, 32'd3, 32'd2, 32'hBEEF_5A44};

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_valid, req_we;
   logic [31:0]  req_addr, req_wdata;
   logic [2:0]   req_funct3;
   logic [31:0]  rdata;
   logic         stall, hit, mem_req, mem_we;
   logic [31:0]  mem_addr;
   logic [127:0] mem_wdata, mem_rdata;
   logic         mem_ready;

   int n_checks = 0;
   int n_pass   = 0;

   dcache_2way dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_funct3 (req_funct3),
      .rdata      (rdata),
      .stall      (stall),
      .hit        (hit),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] f3);
      req_valid  = 1'b1;
      req_we     = we;
      req_addr   = addr;
      req_wdata  = wd;
      req_funct3 = f3;
   endtask

   // Single-cycle hitting load with expected data
   task automatic load_hit(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] exp);
      set_req(1'b0, addr, 32'h0, f3);
      #1;
      check({tag, "_hit"}, hit, 1'b1);
      check({tag, "_stall"}, stall, 1'b0);
      check({tag, "_rdata"}, rdata, exp);
      tick();
   endtask

   // Single-cycle hitting store
   task automatic store_hit(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [2:0] f3);
      set_req(1'b1, addr, wd, f3);
      #1;
      check({tag, "_hit"}, hit, 1'b1);
      check({tag, "_stall"}, stall, 1'b0);
      tick();
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      req_funct3 = '0; mem_rdata = '0; mem_ready = 1'b0;

      // Reset: outputs quiet, even with a request presented
      #1;
      check("rst_stall", stall, 1'b0);
      check("rst_hit", hit, 1'b0);
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 128'h0);
      check("rst_rdata", rdata, 32'h0);
      set_req(1'b0, 32'h100, 32'h0, LW);
      #1;
      check("rst_req_stall", stall, 1'b0);
      req_valid = 1'b0;
      tick();
      rst_n = 1'b1;

      // Cold miss on lw 0x100, refill {4,3,2,1}, re-lookup hit
      set_req(1'b0, 32'h100, 32'h0, LW);
      #1;
      check("miss_stall", stall, 1'b1);
      check("miss_hit", hit, 1'b0);
      check("miss_mem_req", mem_req, 1'b0);
      tick();
      check("refill_req", mem_req, 1'b1);
      check("refill_we", mem_we, 1'b0);
      check("refill_addr", mem_addr, 32'h100);
      check("refill_stall", stall, 1'b1);
      mem_ready = 1'b1; mem_rdata = LINE_A;
      tick();
      mem_ready = 1'b0;
      load_hit("relookup", 32'h100, LW, 32'd1);
      load_hit("lw_10c", 32'h10C, LW, 32'd4);
      load_hit("lw_misalign", 32'h107, LW, 32'd2);

      // Load extension on word 0x0000_80FF
      store_hit("sw_80ff", 32'h100, 32'h0000_80FF, SW);
      load_hit("lb_101", 32'h101, LB, 32'hFFFF_FF80);
      load_hit("lbu_101", 32'h101, LBU, 32'h0000_0080);
      load_hit("lh_100", 32'h100, LH, 32'hFFFF_80FF);
      load_hit("lhu_103", 32'h103, LHU, 32'h0000_0000);
      load_hit("lb_100", 32'h100, LB, 32'hFFFF_FFFF);

      // Store merging: only addressed lanes change
      store_hit("sw_1122", 32'h100, 32'h1122_3344, SW);
      store_hit("sh_beef", 32'h102, 32'hFFFF_BEEF, SH);
      load_hit("lw_beef", 32'h100, LW, 32'hBEEF_3344);
      store_hit("sb_5a", 32'h101, 32'h1234_565A, SB);
      load_hit("lw_5a", 32'h100, LW, 32'hBEEF_5A44);
      load_hit("lw_104", 32'h104, LW, 32'd2);

      // Fill way 1 of set 0 (clean, no write-back)
      set_req(1'b0, 32'h200, 32'h0, LW);
      #1;
      check("m200_stall", stall, 1'b1);
      tick();
      check("m200_we", mem_we, 1'b0);
      check("m200_addr", mem_addr, 32'h200);
      mem_ready = 1'b1; mem_rdata = LINE_B;
      tick();
      mem_ready = 1'b0;
      load_hit("m200_relookup", 32'h200, LW, 32'hB000_0000);

      // Touch way 0, then a third tag evicts clean way 1 directly
      load_hit("touch0_a", 32'h100, LW, 32'hBEEF_5A44);
      set_req(1'b0, 32'h300, 32'h0, LW);
      #1;
      check("m300_stall", stall, 1'b1);
      tick();
      check("m300_we", mem_we, 1'b0);
      check("m300_addr", mem_addr, 32'h300);
      mem_ready = 1'b1; mem_rdata = LINE_C;
      tick();
      mem_ready = 1'b0;
      load_hit("m300_relookup", 32'h300, LW, 32'hC000_0000);
      load_hit("way0_kept", 32'h100, LW, 32'hBEEF_5A44);

      // Dirty way 1, touch way 0, then a miss writes way 1 back
      store_hit("sw_304", 32'h304, 32'h1234_5678, SW);
      load_hit("touch0_b", 32'h100, LW, 32'hBEEF_5A44);
      set_req(1'b0, 32'h200, 32'h0, LW);
      #1;
      check("wb1_miss_stall", stall, 1'b1);
      tick();
      for (int i = 0; i < 10; i++) begin
         check("wb1_hold_stall", stall, 1'b1);
         check("wb1_hold_req", mem_req, 1'b1);
         check("wb1_hold_we", mem_we, 1'b1);
         check("wb1_hold_addr", mem_addr, 32'h300);
         check("wb1_hold_wdata", mem_wdata, WB_C);
         tick();
      end
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      check("wb1_refill_req", mem_req, 1'b1);
      check("wb1_refill_we", mem_we, 1'b0);
      check("wb1_refill_addr", mem_addr, 32'h200);
      mem_ready = 1'b1; mem_rdata = LINE_D;
      tick();
      mem_ready = 1'b0;
      load_hit("wb1_relookup", 32'h200, LW, 32'hD000_0000);

      // Way 0 now LRU and dirty from the stores: write-back shows its data
      set_req(1'b0, 32'h300, 32'h0, LW);
      #1;
      check("wb0_miss_stall", stall, 1'b1);
      tick();
      check("wb0_we", mem_we, 1'b1);
      check("wb0_addr", mem_addr, 32'h100);
      check("wb0_wdata", mem_wdata, WB_A);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      check("wb0_refill_addr", mem_addr, 32'h300);
      check("wb0_refill_req", mem_req, 1'b1);

      // Reset in the middle of the refill drops the request at once
      rst_n = 1'b0;
      #1;
      check("midrst_mem_req", mem_req, 1'b0);
      check("midrst_stall", stall, 1'b0);
      check("midrst_mem_addr", mem_addr, 32'h0);
      tick();
      rst_n = 1'b1;
      set_req(1'b0, 32'h100, 32'h0, LW);
      #1;
      check("postrst_stall", stall, 1'b1);
      check("postrst_hit", hit, 1'b0);
      tick();
      check("postrst_we", mem_we, 1'b0);
      check("postrst_addr", mem_addr, 32'h100);
      mem_ready = 1'b1; mem_rdata = LINE_A;
      tick();
      mem_ready = 1'b0;
      load_hit("postrst_relookup", 32'h100, LW, 32'd1);

      // Idle: no request, stray mem_ready ignored
      req_valid = 1'b0;
      #1;
      check("idle_stall", stall, 1'b0);
      check("idle_hit", hit, 1'b0);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      #1;
      check("idle_mem_req", mem_req, 1'b0);
      check("idle_stall2", stall, 1'b0);
      tick();
      load_hit("idle_after", 32'h108, LW, 32'd3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dcache_2way.md
DCACHE_2WAY -- requirements
Module: dcache_2way

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the CPU word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning the byte address width.
REQ-003 SHALL have parameter WORDS_PER_LINE, default 4, meaning words per line (power of 2, ≥2).
REQ-004 SHALL have parameter NUM_SETS, default 4, meaning sets per way (power of 2, ≥2).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port req_valid, input, 1 bit: CPU access request.
REQ-008 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-009 SHALL have port req_addr, input, ADDR_WIDTH bits: byte address.
REQ-010 SHALL have port req_wdata, input, DATA_WIDTH bits: store data, right-aligned.
REQ-011 SHALL have port req_funct3, input, 3 bits: RISC-V size/sign code.
REQ-012 SHALL have port rdata, output, DATA_WIDTH bits: load result, extended.
REQ-013 SHALL have port stall, output, 1 bit: request not completed this cycle.
REQ-014 SHALL have port hit, output, 1 bit: tag match this cycle.
REQ-015 SHALL have port mem_req, output, 1 bit: memory line transfer request.
REQ-016 SHALL have port mem_we, output, 1 bit: 1 = write-back, 0 = refill.
REQ-017 SHALL have port mem_addr, output, ADDR_WIDTH bits: line-aligned byte address.
REQ-018 SHALL have port mem_wdata, output, WORDS_PER_LINE*DATA_WIDTH bits: victim line, word 0 in the LSBs.
REQ-019 SHALL have port mem_rdata, input, WORDS_PER_LINE*DATA_WIDTH bits: refill line, word 0 in the LSBs.
REQ-020 SHALL have port mem_ready, input, 1 bit: one-cycle pulse; transfer completes this edge.

Function
REQ-021 SHALL decode req_addr as byte[1:0], word offset[log2(WORDS_PER_LINE)+1:2], index next log2(NUM_SETS) bits, and tag the remaining upper bits.
REQ-022 SHALL be 2-way set-associative and write-back/write-allocate, with per-line valid, dirty and tag, plus one LRU bit per set.
REQ-023 SHALL, in IDLE with req_valid and a hit, return rdata combinationally in the same cycle with stall=0, hit=1, and commit a store at the next edge, setting dirty.
REQ-024 SHALL, on any hit, set the set's LRU bit to point at the other way.
REQ-025 SHALL handle loads as follows: funct3 000/001/100/101 select the byte/half at addr[1:0]/addr[1]; 000/001 sign-extend; 100/101 zero-extend; 010 and all other codes return the full word.
REQ-026 SHALL handle stores as follows: funct3 000 writes the addressed byte lane only, 001 writes the addressed half only, all other codes write the word; unaddressed lanes are unchanged.
REQ-027 SHALL select the victim as the first invalid way, way 0 before way 1, otherwise the LRU way.
REQ-028 SHALL implement FSM states IDLE, WRITEBACK and REFILL: IDLE goes on miss to WRITEBACK if the victim is valid and dirty, else to REFILL; WRITEBACK goes to REFILL on mem_ready; REFILL goes to IDLE on mem_ready.
REQ-029 SHALL, in WRITEBACK, drive mem_req=1, mem_we=1, mem_addr={victim tag, index, zeros} and mem_wdata=victim line, all held stable until mem_ready.
REQ-030 SHALL, in REFILL, drive mem_req=1, mem_we=0 and mem_addr=line-aligned req_addr, and on mem_ready write mem_rdata into the victim with valid=1, dirty=0 and the new tag.
REQ-031 SHALL drive stall=1 in WRITEBACK and REFILL and on the miss cycle in IDLE; the re-lookup in IDLE after refill hits and completes the access, giving a clean miss latency of 2 cycles plus memory latency.
REQ-032 SHALL require the CPU to hold all req_* stable while stall=1; behaviour on violation is undefined.
REQ-033 SHALL, with req_valid=0, drive stall=0 and hit=0 and change no state.
REQ-034 SHALL keep mem_req=0 in IDLE and SHALL ignore mem_ready outside WRITEBACK and REFILL.
REQ-035 SHALL ignore misaligned low bits: a half access uses addr[1] only, and a word access ignores addr[1:0].

Reset
REQ-036 SHALL, while rst_n=0, immediately force state=IDLE and clear all valid, dirty and LRU bits; data and tag arrays are not reset.
REQ-037 SHALL drive these outputs during reset: stall=0, hit=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0.
REQ-038 SHALL, on reset asserted mid-WRITEBACK or mid-REFILL, abandon the transfer, drop mem_req immediately and lose dirty data.

Structure
REQ-039 SHALL place the FSM state enum, the funct3 load/store codes and the address-field width functions in the shared package cache_pkg.
REQ-040 SHALL implement byte-lane load extraction/extension and store merging in the combinational sub-module cache_lane_align.

Verification
REQ-041 SHALL test reset then a load (0x100, lw): stall=1 and REFILL at 0x100; mem_ready with line {4,3,2,1} gives rdata=1 and stall=0 on the re-lookup.
REQ-042 SHALL test lb at 0x101 with word 0x0000_80FF, expecting rdata=0xFFFF_FF80, and lbu expecting rdata=0x0000_0080.
REQ-043 SHALL test sh 0xBEEF at 0x102 with word 0x1122_3344, expecting a later lw to return 0xBEEF_3344 and dirty=1.
REQ-044 SHALL test filling both ways of set 0, touching way 0, then missing a third tag: way 1 is evicted, and WRITEBACK occurs first only if way 1 is dirty.
REQ-045 SHALL test rst_n pulsed low during REFILL: mem_req=0 in the same cycle, then the next access misses.
REQ-046 SHALL test mem_ready held off for 10 cycles: stall and mem_* stay stable throughout.
